// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter: default widths used by the
// memory decoder and VGA controller, and the arbiter's state encoding.
package vga_fb_arbiter_pkg;

    localparam int FB_AW         = 11;
    localparam int FB_DW         = 32;
    localparam int FB_MAX_STREAK = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_CPU_RD = 1'b1
    } fbState_e;

    // A zero-width counter is not legal, so MAX_STREAK=0 still gets one bit.
    function automatic int streakWidth(input int maxStreak);
        return (maxStreak > 0) ? $clog2(maxStreak + 1) : 1;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the CPU data port, the scan-out reader and the frame-buffer RAM.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface vga_fb_arbiter_if
    import vga_fb_arbiter_pkg::*;
#(
    parameter int AW = FB_AW,
    parameter int DW = FB_DW
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;

    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic          vga_valid;
    logic [DW-1:0] vga_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_gnt, vga_valid, vga_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_gnt, vga_valid, vga_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out has priority, the CPU is forced a
// slot after MAX_STREAK consecutive display grants while it waits.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int AW         = FB_AW,
    parameter int DW         = FB_DW,
    parameter int MAX_STREAK = FB_MAX_STREAK
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_fb_arbiter_if.slave  bus
);

    localparam int            SW         = streakWidth(MAX_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    fbState_e      state;
    fbState_e      stateNext;
    logic [SW-1:0] streak;
    logic [SW-1:0] streakNext;
    logic          cpuForced;
    logic          gntVga;
    logic          gntCpu;
    logic          vgaValid;
    logic [DW-1:0] cpuRdataHold;

    // Grants are gated by rst_n so the RAM port stays quiet while reset is held.
    always_comb begin
        cpuForced = bus.cpu_req && (streak == STREAK_MAX) && (state != ST_CPU_RD);
        gntVga    = rst_n && bus.vga_req && !cpuForced;
        gntCpu    = rst_n && !gntVga && bus.cpu_req && (state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = ST_IDLE;
        if (gntCpu && !bus.cpu_we) begin
            stateNext = ST_CPU_RD;
        end
    end

    always_comb begin
        bus.vga_gnt   = gntVga;
        bus.ram_en    = gntVga || gntCpu;
        bus.ram_we    = gntCpu && bus.cpu_we;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (gntVga) begin
            bus.ram_addr = bus.vga_addr;
        end else if (gntCpu) begin
            bus.ram_addr = bus.cpu_addr;
        end
        if (gntCpu && bus.cpu_we) begin
            bus.ram_wdata = bus.cpu_wdata;
        end
        // A granted write retires at once; a granted read stalls through its grant cycle.
        bus.cpu_stall = bus.cpu_req && (state == ST_IDLE) && !(gntCpu && bus.cpu_we);
        bus.cpu_rdata = (state == ST_CPU_RD) ? bus.ram_rdata : cpuRdataHold;
        bus.vga_valid = vgaValid;
        bus.vga_rdata = vgaValid ? bus.ram_rdata : '0;
    end

    // Streak only grows while the CPU is actually waiting on display grants.
    always_comb begin
        streakNext = streak;
        if (!bus.cpu_req || gntCpu) begin
            streakNext = '0;
        end else if (gntVga && (streak != STREAK_MAX)) begin
            streakNext = streak + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else begin
            streak <= streakNext;
        end
    end

    // The RAM's own output register supplies the one-cycle data latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgaValid     <= 1'b0;
            cpuRdataHold <= '0;
        end else begin
            vgaValid <= gntVga;
            if (state == ST_CPU_RD) begin
                cpuRdataHold <= bus.ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios followed by randomized
// CPU/display traffic, compared against a shadow-memory reference model.
module tb_vga_fb_arbiter;
    import vga_fb_arbiter_pkg::*;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int NW   = 1 << AW;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vga_fb_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAXS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initWord(input int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // Behavioural synchronous RAM, contents reloaded while reset is held.
    logic [DW-1:0] mem [0:NW-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) mem[i] <= initWord(i);
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [0:NW-1];
    bit            mRd;
    int            mStreak;
    bit            prevVg;
    logic [DW-1:0] vgaExp;
    logic [DW-1:0] mRdExp;
    logic [DW-1:0] mLastRd;

    // Observations captured at the last check point
    logic          oStall, oGnt, oWe, oVgaValid;
    int            oStreak;
    logic [DW-1:0] oCpuRdata, oVgaRdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mRd     = 0;
        mStreak = 0;
        prevVg  = 0;
        mLastRd = '0;
        mRdExp  = '0;
        vgaExp  = '0;
        for (int i = 0; i < NW; i++) shadow[i] = initWord(i);
    endtask

    task automatic doReset(input logic creq);
        @(posedge clk); #1;
        rst_n         = 1'b0;
        bus.cpu_req   = creq;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = 11'h005;
        #4;
        check("rst_vga_valid", bus.vga_valid, 1'b0);
        check("rst_vga_gnt",   bus.vga_gnt,   1'b0);
        check("rst_ram_en",    bus.ram_en,    1'b0);
        check("rst_ram_we",    bus.ram_we,    1'b0);
        check("rst_ram_addr",  bus.ram_addr,  '0);
        check("rst_ram_wdata", bus.ram_wdata, '0);
        check("rst_cpu_rdata", bus.cpu_rdata, '0);
        check("rst_cpu_stall", bus.cpu_stall, creq);
        check("rst_state",     64'(dut.state), 64'(ST_IDLE));
        @(posedge clk); #1;
        rst_n       = 1'b1;
        bus.cpu_req = 1'b0;
        bus.vga_req = 1'b0;
        modelReset();
    endtask

    task automatic cycle(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                         input logic [DW-1:0] cwd, input logic vreq, input logic [AW-1:0] vaddr);
        bit            expVg, expCg, expStall, expWe;
        logic [AW-1:0] expAddr;
        @(posedge clk); #1;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.vga_req   = vreq;
        bus.vga_addr  = vaddr;
        #4;
        expVg    = vreq && !(creq && (mStreak == MAXS) && !mRd);
        expCg    = !expVg && creq && !mRd;
        expStall = creq && !mRd && !(expCg && cwe);
        expWe    = expCg && cwe;
        expAddr  = expVg ? vaddr : caddr;
        check("vga_gnt",   bus.vga_gnt,   expVg);
        check("cpu_stall", bus.cpu_stall, expStall);
        check("ram_en",    bus.ram_en,    expVg || expCg);
        check("ram_we",    bus.ram_we,    expWe);
        if (expVg || expCg) check("ram_addr", bus.ram_addr, expAddr);
        if (expWe) check("ram_wdata", bus.ram_wdata, cwd);
        check("vga_valid", bus.vga_valid, prevVg);
        if (prevVg) check("vga_rdata", bus.vga_rdata, vgaExp);
        check("cpu_rdata", bus.cpu_rdata, mRd ? mRdExp : mLastRd);
        oStall    = bus.cpu_stall;
        oGnt      = bus.vga_gnt;
        oWe       = bus.ram_we;
        oVgaValid = bus.vga_valid;
        oVgaRdata = bus.vga_rdata;
        oCpuRdata = bus.cpu_rdata;
        oStreak   = int'(dut.streak);
        if (mRd) mLastRd = mRdExp;
        if (expCg && !cwe) mRdExp = shadow[caddr];
        if (expVg) vgaExp = shadow[vaddr];
        if (expWe) shadow[caddr] = cwd;
        prevVg = expVg;
        if (!creq || expCg)                  mStreak = 0;
        else if (expVg && (mStreak < MAXS))  mStreak++;
        mRd = expCg && !cwe;
    endtask

    initial begin
        logic [AW-1:0] va;
        logic          cReq, cWe, vReq;
        logic [AW-1:0] cAddr, vAddr;
        logic [DW-1:0] cWd;
        int            cw;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        doReset(1'b1);

        // Reset while a CPU read is in its data cycle
        cycle(1, 0, 11'h007, '0, 0, '0);
        check("t1_rd_stall", oStall, 1'b1);
        doReset(1'b0);
        cycle(0, 0, '0, '0, 0, '0);
        check("t1_no_valid", oVgaValid, 1'b0);

        // CPU write then read back
        cycle(1, 1, 11'h010, 32'hDEAD_BEEF, 0, '0);
        check("t2_wr_we",    oWe,    1'b1);
        check("t2_wr_stall", oStall, 1'b0);
        cycle(1, 0, 11'h010, '0, 0, '0);
        check("t2_rd_stall", oStall, 1'b1);
        cycle(1, 0, 11'h010, '0, 0, '0);
        check("t2_rd_done",  oStall,    1'b0);
        check("t2_rd_data",  oCpuRdata, 32'hDEAD_BEEF);
        cycle(0, 0, '0, '0, 0, '0);
        check("t2_rd_hold",  oCpuRdata, 32'hDEAD_BEEF);

        // Display back-to-back
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, '0, '0, 1, AW'(i));
            check("t3_gnt", oGnt, 1'b1);
        end
        cycle(0, 0, '0, '0, 0, '0);
        check("t3_last_valid", oVgaValid, 1'b1);
        check("t3_last_data",  oVgaRdata, initWord(3));

        // Continuous contention: four display grants, then the CPU
        va = 11'h100;
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 11'h020, 32'h1234_5678, 1, va);
            check("t4_gnt",    oGnt,    (k < 4));
            check("t4_stall",  oStall,  (k < 4));
            check("t4_streak", oStreak, k);
            if (oGnt) va++;
        end
        cycle(0, 0, '0, '0, 1, va);
        check("t4_resume_gnt", oGnt,    1'b1);
        check("t4_streak_clr", oStreak, 0);
        va++;

        // Display granted in the CPU read data cycle
        cycle(1, 0, 11'h030, '0, 0, '0);
        cycle(1, 0, 11'h030, '0, 1, 11'h031);
        check("t5_gnt",     oGnt,      1'b1);
        check("t5_cpu_dat", oCpuRdata, initWord(32'h30));
        cycle(0, 0, '0, '0, 0, '0);
        check("t5_vga_dat", oVgaRdata, initWord(32'h31));
        check("t5_cpu_hld", oCpuRdata, initWord(32'h30));

        // CPU gives up mid-streak
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 11'h040, 32'hCAFE_0000, 1, va);
            va++;
        end
        cycle(0, 0, '0, '0, 1, va);
        check("t6_streak3", oStreak, 3);
        cycle(0, 0, '0, '0, 0, '0);
        check("t6_streak0", oStreak, 0);

        // Randomized traffic obeying the hold-while-stalled protocols
        cReq = 0; cWe = 0; cAddr = '0; cWd = '0; vReq = 0; vAddr = '0;
        oStall = 0; oGnt = 0; cw = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!(cReq && oStall)) begin
                cReq  = ($urandom % 2) == 0;
                cWe   = ($urandom % 2) == 0;
                cAddr = AW'($urandom % 64);
                cWd   = $urandom;
            end
            if (!(vReq && !oGnt)) begin
                vReq  = ($urandom % 4) != 0;
                vAddr = AW'($urandom % 64);
            end
            cycle(cReq, cWe, cAddr, cWd, vReq, vAddr);
            if (cReq && oStall) begin
                cw++;
            end else if (cReq) begin
                check("cpu_wait_bound", (cw <= MAXS + 1), 1'b1);
                cw = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
